// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
// Exports ADD_W, N_REQ, req_id_t, word_t, s1_entry_t and pick_grant().
package adder_arb_pkg;

  localparam int ADD_W = 16;
  localparam int N_REQ = 2;

  typedef logic [0:0] req_id_t;
  typedef logic [ADD_W-1:0] word_t;

  typedef struct packed {
    word_t   a;
    word_t   b;
    logic    cin;
    req_id_t id;
  } s1_entry_t;

  // Round-robin pick: when both requesters are valid, the one
  // that did not win last time goes; otherwise the lone valid
  // requester goes (0 when nobody is valid, gated elsewhere).
  function automatic req_id_t pick_grant(
    input logic [N_REQ-1:0] valid,
    input req_id_t          last
  );
    req_id_t g;
    g = '0;
    unique case (1'b1)
      (valid == 2'b11): g = ~last;
      (valid == 2'b10): g = 1'b1;
      default:          g = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/cla_adder_w.sv
// W-bit carry-lookahead adder: 4-bit lookahead groups chained by
// group generate/propagate. Ports: a, b, cin -> sum, cout. W % 4 == 0.
module cla_adder_w
  import adder_arb_pkg::*;
#(
  parameter int W = ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1]
               & g[4*k]);
    end

    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    // Carries inside each group look ahead from the group carry-in.
    for (int k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k]
               | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & gc[k]);
    end

    sum  = p ^ c;
    cout = gc[NG];
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter + 2-stage pipeline time-sharing one CLA adder.
// In: clk, rst (sync, high), req_valid/a/b[/sub], rsp_ready. Out:
// req_ready, rsp_valid/id/sum/cout. ADD_ARB_SUB_EN adds req_sub.
module adder_arbiter
  import adder_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ADD_W-1:0] req_a,
  input  logic [N_REQ*ADD_W-1:0] req_b,
`ifdef ADD_ARB_SUB_EN
  input  logic [N_REQ-1:0]       req_sub,
`endif
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [ADD_W-1:0]       rsp_sum,
  output logic                   rsp_cout
);

  localparam int W = ADD_W;

  s1_entry_t s1;
  logic      s1_v;
  req_id_t   last_grant;

  logic      s2_free;
  logic      s1_free;
  req_id_t   grant;
  logic      xfer;
  s1_entry_t s1_next;

  logic [W-1:0] add_b;
  logic [W-1:0] add_sum;
  logic         add_cout;

  assign s2_free = !rsp_valid || rsp_ready;
  assign s1_free = !s1_v || s2_free;

  always_comb begin
    grant     = pick_grant(req_valid, last_grant);
    req_ready = '0;
    if (!rst && s1_free) begin
      req_ready[grant] = req_valid[grant];
    end
    xfer = |(req_valid & req_ready);

    s1_next.a   = req_a[grant*W +: W];
    s1_next.b   = req_b[grant*W +: W];
    s1_next.id  = grant;
`ifdef ADD_ARB_SUB_EN
    s1_next.cin = req_sub[grant];
`else
    s1_next.cin = 1'b0;
`endif
  end

  // cin doubles as the subtract flag: a - b == a + ~b + 1.
`ifdef ADD_ARB_SUB_EN
  assign add_b = s1.cin ? ~s1.b : s1.b;
`else
  assign add_b = s1.b;
`endif

  cla_adder_w #(
    .W (W)
  ) u_cla (
    .a    (s1.a),
    .b    (add_b),
    .cin  (s1.cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1   <= '0;
    end else if (s1_free) begin
      s1_v <= xfer;
      if (xfer) begin
        s1 <= s1_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else if (s1_v && s2_free) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1.id;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: handshake, arbitration,
// backpressure, reset and (with ADD_ARB_SUB_EN) subtract.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef ADD_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag,
                     input logic        id,
                     input logic [15:0] sum,
                     input logic        cout);
    chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(sum));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(cout));
  endtask

  task automatic set0(input logic [15:0] a,
                      input logic [15:0] b);
    req_a[15:0] = a;
    req_b[15:0] = b;
  endtask

  task automatic set1(input logic [15:0] a,
                      input logic [15:0] b);
    req_a[31:16] = a;
    req_b[31:16] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_v", 32'(rsp_valid), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    tick();

    // single request from requester 0
    set0(16'h1234, 16'h0FED);
    req_valid = 2'b01;
    #1;
    chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    chk("single_lat", 32'(rsp_valid), 32'd0);
    tick();
    rsp("single", 1'b0, 16'h2221, 1'b0);

    // overflow from requester 1
    set1(16'hFFFF, 16'h0001);
    req_valid = 2'b10;
    #1;
    chk("ovf_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    rsp("ovf", 1'b1, 16'h0000, 1'b1);

    // fairness: both valid for 4 cycles
    set0(16'h1111, 16'h2222);
    set1(16'h8000, 16'h8001);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req_valid = 2'b11;
        #1;
        chk($sformatf("rr_ready%0d", i), 32'(req_ready),
            (i % 2 == 0) ? 32'd1 : 32'd2);
      end else begin
        req_valid = 2'b00;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        if ((i - 1) % 2 == 0)
          rsp($sformatf("rr%0d", i - 1), 1'b0, 16'h3333, 1'b0);
        else
          rsp($sformatf("rr%0d", i - 1), 1'b1, 16'h0001, 1'b1);
      end
    end
    chk("rr_drain", 32'(rsp_valid), 32'd0);

    // backpressure: three back-to-back requests, consumer stalled
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set0(16'h0001, 16'h0002);
    #1;
    chk("bp_ready0", 32'(req_ready), 32'd1);
    tick();
    set0(16'h0010, 16'h0020);
    #1;
    chk("bp_ready1", 32'(req_ready), 32'd1);
    tick();
    set0(16'h0100, 16'h0200);
    #1;
    chk("bp_ready2", 32'(req_ready), 32'd0);
    rsp("bp_hold0", 1'b0, 16'h0003, 1'b0);
    tick();
    chk("bp_ready3", 32'(req_ready), 32'd0);
    rsp("bp_hold1", 1'b0, 16'h0003, 1'b0);
    tick();
    rsp("bp_hold2", 1'b0, 16'h0003, 1'b0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    rsp("bp_out1", 1'b0, 16'h0030, 1'b0);
    tick();
    rsp("bp_out2", 1'b0, 16'h0300, 1'b0);
    tick();
    chk("bp_nodup", 32'(rsp_valid), 32'd0);

    // reset with two items in flight (both from requester 0)
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set0(16'h0AAA, 16'h0111);
    tick();
    set0(16'h0BBB, 16'h0111);
    tick();
    chk("mid_full", 32'(rsp_valid), 32'd1);
    req_valid = 2'b11;
    rst = 1'b1;
    tick();
    chk("mid_ready", 32'(req_ready), 32'd0);
    chk("mid_v", 32'(rsp_valid), 32'd0);
    chk("mid_sum", 32'(rsp_sum), 32'd0);
    chk("mid_id", 32'(rsp_id), 32'd0);
    chk("mid_cout", 32'(rsp_cout), 32'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    chk("mid_stale0", 32'(rsp_valid), 32'd0);
    tick();
    chk("mid_stale1", 32'(rsp_valid), 32'd0);
    set0(16'h0002, 16'h0003);
    set1(16'h0004, 16'h0005);
    req_valid = 2'b11;
    #1;
    chk("mid_grant0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    rsp("mid_rsp", 1'b0, 16'h0005, 1'b0);
    tick();

`ifdef ADD_ARB_SUB_EN
    req_sub   = 2'b01;
    req_valid = 2'b01;
    set0(16'h0005, 16'h0007);
    tick();
    set0(16'h0007, 16'h0005);
    tick();
    req_valid = 2'b00;
    rsp("sub0", 1'b0, 16'hFFFE, 1'b0);
    tick();
    rsp("sub1", 1'b0, 16'h0002, 1'b1);
    req_sub = 2'b00;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Two-requester, round-robin arbiter and pipeline sequencer for the shared 16-bit carry-lookahead adder. It accepts add requests from two clients over valid/ready handshakes and registers the operands. It drives the adder core and returns a registered, ID-tagged result over a valid/ready response port with backpressure. It sits between the ALU issue logic and the single adder instance so that the adder is time-shared without combinational paths from requesters to the result.

## Interface
- W, 16, operand/result width
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; transfer when req_valid[i] & req_ready[i]
- req_a  in  2*W  operand A; requester i at [i*W +: W]
- req_b  in  2*W  operand B; same packing
- req_sub  in  2  per-requester subtract select (only with ADD_ARB_SUB_EN)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index of result
- rsp_sum  out  W  sum/difference, modulo 2^W
- rsp_cout  out  1  adder carry-out

Reset rst, synchronous, active-high; clock clk.

## Operation
- Two pipeline stages:
  - S1: operand register (a, b, cin, id, s1_v).
  - S2: output register (rsp_*, rsp_valid).
- S2 advance: s2_free = !rsp_valid | rsp_ready.
- S1 advance: s1_free = !s1_v | s2_free.
- Arbitration (combinational, each cycle):
  - Pointer last_grant; 1 after reset, so requester 0 has priority first.
  - If both requesters are valid, grant !last_grant; if one is valid, grant it.
  - req_ready[g] = s1_free & req_valid[g]; the non-granted bit is 0.
  - last_grant updates only on an accepted transfer.
- On transfer: S1 loads the granted a, b, id, s1_v=1. Without a transfer while s1_free: s1_v=0.
- Adder inputs come only from S1 registers: cin=0, b as-is (subtract variant in Configuration).
- When s1_v & s2_free: S2 loads sum, cout and id, and sets rsp_valid=1.
- rsp_valid & rsp_ready with no new S1 data: rsp_valid=0.
- Stall: while rsp_valid & !rsp_ready, rsp_* hold stable. S1 holds if full; req_ready=0 only if S1 is full.
- Boundaries:
  - Overflow wraps modulo 2^W; carry is reported in rsp_cout.
  - A request arriving in the same cycle as a response handshake is accepted (full throughput).
  - Reset mid-operation drops in-flight items; no response is produced for them.

## Timing
- Reset values: req_ready=0 during reset; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0; S1 cleared; last_grant=1.
- Latency: request accepted at edge N -> rsp_valid high after edge N+1 (2 edges), with no stall.
- Throughput: 1 result/cycle sustained when rsp_ready=1.
- Buffering: max 2 items in flight. With rsp_ready=0, the second item parks in S1 and req_ready drops after that.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.
- Adder path is S1 register -> adder -> S2 register: one full cycle, no requester-to-output combinational path.

## Configuration
- ADD_ARB_SUB_EN defined:
  - The req_sub port exists and is captured into S1 with the operands.
  - When the sub bit is set, the adder receives ~b and cin=1, so rsp_sum = a - b mod 2^W.
  - rsp_cout=1 means no borrow.
- ADD_ARB_SUB_EN undefined: req_sub is absent and all operations are add, with cin=0.

## Structure
- Package adder_arb_pkg:
  - ADD_W=16, N_REQ=2.
  - Typedef req_id_t (1 bit).
  - Typedef s1_entry_t {a, b, cin, id}.
- One sub-module: cla_adder_w, the W-bit CLA core (a, b, cin -> sum, cout), instantiated once. Arbitration, pipeline control and the subtract mux stay in adder_arbiter.

## Test plan
- Reset, then single request (req0: a=0x1234, b=0x0FED) -> req_ready[0]=1, then rsp_valid 2 edges later with sum=0x2221, cout=0, id=0.
- Overflow (req1: a=0xFFFF, b=0x0001) -> sum=0x0000, cout=1, id=1.
- Both requesters valid for 4 cycles, rsp_ready=1 -> responses with ids 0,1,0,1, one per cycle, with correct sums.
- Backpressure: rsp_ready=0 during 3 back-to-back requests -> first result held stable, second accepted into S1, req_ready=0 on the third. Release rsp_ready -> all three delivered in order, none lost or duplicated.
- rst asserted with 2 items in flight -> next cycle rsp_valid=0, outputs zero, no stale response after deassert, req0 granted first.
- (ADD_ARB_SUB_EN) req0 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
